reg_file_rename: RTL and testbench

- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the decoder.
- Decoder reads operand value/busy/tag through combinational ports and renames a destination register on issue.
- ROB commits write the value and release the rename tag. A flush clears all rename state.

---
 rtl/reg_file_rename_if.sv | 44 ++++
 rtl/reg_file_rename.sv | 93 +++++++++
 tb/tb_reg_file_rename.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rename_if.sv
// Decoder/ROB-facing bundle for reg_file_rename: operand reads, rename issue, commit and flush.
// The master side is the decoder/ROB; the slave side is the register file.
interface reg_file_rename_if #(
  parameter int unsigned REG_NUM_WIDTH  = 5,
  parameter int unsigned ROB_SIZE_WIDTH = 5
);
  logic [REG_NUM_WIDTH-1:0]  dec_rs1;
  logic [REG_NUM_WIDTH-1:0]  dec_rs2;
  logic [31:0]               rs1_value;
  logic                      rs1_busy;
  logic [ROB_SIZE_WIDTH-1:0] rs1_rob_id;
  logic [31:0]               rs2_value;
  logic                      rs2_busy;
  logic [ROB_SIZE_WIDTH-1:0] rs2_rob_id;

  logic                      dec_rename_valid;
  logic [REG_NUM_WIDTH-1:0]  dec_rd;
  logic [ROB_SIZE_WIDTH-1:0] dec_rob_id;

  logic                      rob_commit_valid;
  logic [REG_NUM_WIDTH-1:0]  rob_commit_rd;
  logic [31:0]               rob_commit_value;
  logic [ROB_SIZE_WIDTH-1:0] rob_commit_rob_id;

  logic                      flush;

  modport master (
    output dec_rs1, dec_rs2,
    input  rs1_value, rs1_busy, rs1_rob_id,
    input  rs2_value, rs2_busy, rs2_rob_id,
    output dec_rename_valid, dec_rd, dec_rob_id,
    output rob_commit_valid, rob_commit_rd, rob_commit_value, rob_commit_rob_id,
    output flush
  );

  modport slave (
    input  dec_rs1, dec_rs2,
    output rs1_value, rs1_busy, rs1_rob_id,
    output rs2_value, rs2_busy, rs2_rob_id,
    input  dec_rename_valid, dec_rd, dec_rob_id,
    input  rob_commit_valid, rob_commit_rd, rob_commit_value, rob_commit_rob_id,
    input  flush
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags, written by ROB commits.
// Define RF_COMMIT_FORWARD_EN to forward a tag-matching commit onto the read ports in the same cycle.
module reg_file_rename #(
  parameter int unsigned REG_NUM        = 32,
  parameter int unsigned REG_NUM_WIDTH  = 5,
  parameter int unsigned ROB_SIZE_WIDTH = 5
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reg_file_rename_if.slave bus
);

  logic [REG_NUM-1:0][31:0]               value_q, value_d;
  logic [REG_NUM-1:0]                     busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_SIZE_WIDTH-1:0] tag_q, tag_d;

  logic commit_en;
  logic rename_en;

  assign commit_en = bus.rob_commit_valid && (bus.rob_commit_rd != '0);
  assign rename_en = bus.dec_rename_valid && (bus.dec_rd != '0) && !bus.flush;

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;

    if (commit_en) begin
      value_d[bus.rob_commit_rd] = bus.rob_commit_value;
      // Only the youngest producer may release the register.
      if (busy_q[bus.rob_commit_rd] && (tag_q[bus.rob_commit_rd] == bus.rob_commit_rob_id)) begin
        busy_d[bus.rob_commit_rd] = 1'b0;
      end
    end

    if (bus.flush) begin
      busy_d = '0;
    end else if (rename_en) begin
      busy_d[bus.dec_rd] = 1'b1;
      tag_d[bus.dec_rd]  = bus.dec_rob_id;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else if (rdy_in) begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  logic [REG_NUM_WIDTH-1:0]  rd_idx   [2];
  logic [31:0]               rd_value [2];
  logic                      rd_busy  [2];
  logic [ROB_SIZE_WIDTH-1:0] rd_tag   [2];

  assign rd_idx[0] = bus.dec_rs1;
  assign rd_idx[1] = bus.dec_rs2;

  for (genvar p = 0; p < 2; p++) begin : g_read
    always_comb begin
      rd_value[p] = value_q[rd_idx[p]];
      rd_busy[p]  = busy_q[rd_idx[p]];
      rd_tag[p]   = busy_q[rd_idx[p]] ? tag_q[rd_idx[p]] : '0;
`ifdef RF_COMMIT_FORWARD_EN
      if (bus.rob_commit_valid && (bus.rob_commit_rd == rd_idx[p]) && busy_q[rd_idx[p]] &&
          (tag_q[rd_idx[p]] == bus.rob_commit_rob_id)) begin
        rd_value[p] = bus.rob_commit_value;
        rd_busy[p]  = 1'b0;
        rd_tag[p]   = '0;
      end
`endif
      if (rd_idx[p] == '0) begin
        rd_value[p] = '0;
        rd_busy[p]  = 1'b0;
        rd_tag[p]   = '0;
      end
    end
  end

  assign bus.rs1_value  = rd_value[0];
  assign bus.rs1_busy   = rd_busy[0];
  assign bus.rs1_rob_id = rd_tag[0];
  assign bus.rs2_value  = rd_value[1];
  assign bus.rs2_busy   = rd_busy[1];
  assign bus.rs2_rob_id = rd_tag[1];

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename; checks both build variants of RF_COMMIT_FORWARD_EN.
module tb_reg_file_rename;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  reg_file_rename_if #(.REG_NUM_WIDTH(5), .ROB_SIZE_WIDTH(5)) bus ();

  reg_file_rename #(
    .REG_NUM       (32),
    .REG_NUM_WIDTH (5),
    .ROB_SIZE_WIDTH(5)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_rename_valid  = 1'b0;
    bus.dec_rd            = '0;
    bus.dec_rob_id        = '0;
    bus.rob_commit_valid  = 1'b0;
    bus.rob_commit_rd     = '0;
    bus.rob_commit_value  = '0;
    bus.rob_commit_rob_id = '0;
    bus.flush             = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    bus.dec_rename_valid = 1'b1;
    bus.dec_rd           = rd;
    bus.dec_rob_id       = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] id, input logic [31:0] val);
    bus.rob_commit_valid  = 1'b1;
    bus.rob_commit_rd     = rd;
    bus.rob_commit_rob_id = id;
    bus.rob_commit_value  = val;
  endtask

  // Read one register on rs1 and compare value/busy/rob_id.
  task automatic expect_rs1(input string name, input logic [4:0] rs, input logic [31:0] val,
                            input logic busy, input logic [4:0] id);
    bus.dec_rs1 = rs;
    #1;
    check({name, ".value"}, bus.rs1_value, val);
    check({name, ".busy"}, {31'b0, bus.rs1_busy}, {31'b0, busy});
    check({name, ".rob_id"}, {27'b0, bus.rs1_rob_id}, {27'b0, id});
  endtask

  initial begin
    idle();
    bus.dec_rs1 = '0;
    bus.dec_rs2 = '0;
    rst = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state on both ports.
    bus.dec_rs2 = 5'd0;
    expect_rs1("rst_x5", 5'd5, 32'h0, 1'b0, 5'd0);
    check("rst_x0_rs2.value", bus.rs2_value, 32'h0);
    check("rst_x0_rs2.busy", {31'b0, bus.rs2_busy}, 32'h0);

    // Commit to x0 is ignored.
    commit(5'd0, 5'd0, 32'hDEAD);
    tick();
    idle();
    expect_rs1("x0_write", 5'd0, 32'h0, 1'b0, 5'd0);

    // Rename then matching commit.
    rename(5'd3, 5'd7);
    tick();
    idle();
    expect_rs1("x3_renamed", 5'd3, 32'h0, 1'b1, 5'd7);
    commit(5'd3, 5'd7, 32'h1234);
    tick();
    tick(); // repeated identical commit is idempotent
    idle();
    expect_rs1("x3_committed", 5'd3, 32'h1234, 1'b0, 5'd0);

    // Older commit does not release a younger producer.
    rename(5'd4, 5'd2);
    tick();
    rename(5'd4, 5'd9);
    tick();
    idle();
    commit(5'd4, 5'd2, 32'h55);
    tick();
    idle();
    expect_rs1("x4_stale_commit", 5'd4, 32'h55, 1'b1, 5'd9);
    commit(5'd4, 5'd9, 32'h66);
    tick();
    idle();
    expect_rs1("x4_final_commit", 5'd4, 32'h66, 1'b0, 5'd0);

    // Commit and rename of the same register in one cycle.
    rename(5'd6, 5'd1);
    tick();
    idle();
    commit(5'd6, 5'd1, 32'hAA);
    rename(5'd6, 5'd12);
    tick();
    idle();
    expect_rs1("x6_commit_rename", 5'd6, 32'hAA, 1'b1, 5'd12);

    // Flush with concurrent commit and rename.
    for (int i = 1; i <= 8; i++) begin
      rename(i[4:0], i[4:0]);
      tick();
    end
    idle();
    expect_rs1("x8_pre_flush", 5'd8, 32'h0, 1'b1, 5'd8);
    bus.flush = 1'b1;
    commit(5'd1, 5'd1, 32'h10);
    rename(5'd9, 5'd20);
    tick();
    idle();
    for (int i = 1; i <= 9; i++) begin
      bus.dec_rs1 = i[4:0];
      #1;
      check($sformatf("flush_busy_x%0d", i), {31'b0, bus.rs1_busy}, 32'h0);
    end
    expect_rs1("x1_flush_commit", 5'd1, 32'h10, 1'b0, 5'd0);
    expect_rs1("x9_flush_rename", 5'd9, 32'h0, 1'b0, 5'd0);

    // Same-cycle visibility of a commit on rs2.
    rename(5'd10, 5'd3);
    tick();
    idle();
    commit(5'd10, 5'd3, 32'h77);
    bus.dec_rs2 = 5'd10;
    #1;
`ifdef RF_COMMIT_FORWARD_EN
    check("fwd_same.value", bus.rs2_value, 32'h77);
    check("fwd_same.busy", {31'b0, bus.rs2_busy}, 32'h0);
    check("fwd_same.rob_id", {27'b0, bus.rs2_rob_id}, 32'h0);
`else
    check("nofwd_same.value", bus.rs2_value, 32'h0);
    check("nofwd_same.busy", {31'b0, bus.rs2_busy}, 32'h1);
    check("nofwd_same.rob_id", {27'b0, bus.rs2_rob_id}, 32'h3);
`endif
    tick();
    idle();
    check("x10_next.value", bus.rs2_value, 32'h77);
    check("x10_next.busy", {31'b0, bus.rs2_busy}, 32'h0);

    // Global enable low holds all state.
    rdy = 1'b0;
    rename(5'd2, 5'd5);
    tick();
    expect_rs1("x2_rdy_low", 5'd2, 32'h0, 1'b0, 5'd0);
    rdy = 1'b1;
    tick();
    idle();
    expect_rs1("x2_rdy_high", 5'd2, 32'h0, 1'b1, 5'd5);

    // Reset clears everything again.
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    expect_rs1("x4_rerst", 5'd4, 32'h0, 1'b0, 5'd0);
    expect_rs1("x2_rerst", 5'd2, 32'h0, 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
